// File: rtl/register_bank_pkg.sv
// register_bank_pkg
//   Shared definitions for the multi-port register bank: parameter defaults,
//   the FSM state encoding and the address-width helper.
package register_bank_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NRD_DEF    = 2;
    localparam int BYPASS_DEF = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Address width for a bank of n registers (never narrower than 1 bit).
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   One pending bit per register. A bit is set by an allocation and cleared
//   by a write on either write port or by the bank clear sequence. Register 0
//   is never pending.
// Ports:
//   clock                     rising-edge clock
//   clr0_en / clr0_addr       write-port-0 clear
//   clr1_en / clr1_addr       write-port-1 clear
//   alloc_en / alloc_addr     mark register pending (wins over a write clear)
//   clear_en / clear_addr     clear-sequence reset of one bit
//   lk_addr / lk_busy         NRD packed lookups of the registered state
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = 5
) (
    input  logic              clock,
    input  logic              clr0_en,
    input  logic [AW-1:0]     clr0_addr,
    input  logic              clr1_en,
    input  logic [AW-1:0]     clr1_addr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              clear_en,
    input  logic [AW-1:0]     clear_addr,
    input  logic [NRD*AW-1:0] lk_addr,
    output logic [NRD-1:0]    lk_busy
);

    logic [NREGS-1:0] r_pend;

    // Priority per bit: clear sequence, then alloc, then write clear.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NREGS; i++) begin
            if (i == 0) begin
                r_pend[i] <= 1'b0;
            end else if (clear_en && (clear_addr == AW'(i))) begin
                r_pend[i] <= 1'b0;
            end else if (alloc_en && (alloc_addr == AW'(i))) begin
                r_pend[i] <= 1'b1;
            end else if ((clr0_en && (clr0_addr == AW'(i))) ||
                         (clr1_en && (clr1_addr == AW'(i)))) begin
                r_pend[i] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_lk
        logic [AW-1:0] w_addr;
        assign w_addr     = lk_addr[k*AW +: AW];
        assign lk_busy[k] = r_pend[w_addr];
    end

endmodule

// File: rtl/register_bank_mp.sv
// register_bank_mp
//   Register file with NRD combinational read ports, two write ports
//   (port 0 = writeback, has priority; port 1 = load return) and a pending
//   scoreboard. After reset a CLEAR phase zeroes registers 1..NREGS-1, one
//   per cycle, before the bank reports ready.
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   we0/ain0/din0                 write port 0
//   we1/ain1/din1                 write port 1
//   alloc_en/alloc_addr           mark destination register pending
//   rs_addr                       NRD packed read addresses
//   rs_val / rs_busy              NRD packed read data / pending bits
//   ready                         high once the clear sequence has completed
module register_bank_mp
    import register_bank_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int BYPASS = BYPASS_DEF,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                we0,
    input  logic [AW-1:0]       ain0,
    input  logic [XLEN-1:0]     din0,
    input  logic                we1,
    input  logic [AW-1:0]       ain1,
    input  logic [XLEN-1:0]     din1,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_val,
    output logic [NRD-1:0]      rs_busy,
    output logic                ready
);

    state_e          r_state, w_state_nxt;
    logic [AW-1:0]   r_clr_idx, w_clr_idx_nxt;
    logic            w_ready, w_in_clear;
    logic            w_act, w_we0, w_we1, w_alloc, w_clr;
    logic [NRD-1:0]  w_lk_busy;
    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= AW'(1);
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_ready       = 1'b0;
        w_in_clear    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_in_clear    = 1'b1;
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == AW'(NREGS - 1)) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_ready = 1'b1;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    assign ready = w_ready;

    // Effective enables: only in READY, never under reset, never to r0.
    // A port-1 write colliding with port 0 is dropped.
    assign w_act   = w_ready && !reset;
    assign w_we0   = w_act && we0 && (ain0 != '0);
    assign w_we1   = w_act && we1 && (ain1 != '0) && !(w_we0 && (ain0 == ain1));
    assign w_alloc = w_act && alloc_en && (alloc_addr != '0);
    assign w_clr   = w_in_clear && !reset;

    always_ff @(posedge clock) begin
        if (w_clr) begin
            r_mem[r_clr_idx] <= '0;
        end else begin
            if (w_we0) r_mem[ain0] <= din0;
            if (w_we1) r_mem[ain1] <= din1;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clock      (clock),
        .clr0_en    (w_we0),
        .clr0_addr  (ain0),
        .clr1_en    (w_we1),
        .clr1_addr  (ain1),
        .alloc_en   (w_alloc),
        .alloc_addr (alloc_addr),
        .clear_en   (w_clr),
        .clear_addr (r_clr_idx),
        .lk_addr    (rs_addr),
        .lk_busy    (w_lk_busy)
    );

    // Read ports: forwarding only touches data; busy stays registered.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic            w_hit0, w_hit1, w_live;
        logic [XLEN-1:0] w_data;
        assign w_addr = rs_addr[k*AW +: AW];
        assign w_live = w_ready && (w_addr != '0);
        assign w_hit0 = (BYPASS != 0) && w_we0 && (ain0 == w_addr);
        assign w_hit1 = (BYPASS != 0) && w_we1 && (ain1 == w_addr);
        assign w_data = w_hit0 ? din0 : (w_hit1 ? din1 : r_mem[w_addr]);
        assign rs_val[k*XLEN +: XLEN] = w_live ? w_data : '0;
        assign rs_busy[k]             = w_live && w_lk_busy[k];
    end

endmodule

// File: tb/tb_register_bank_mp.sv
module tb_register_bank_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int K_VAL  = 0;
    localparam int K_BUSY = 1;
    localparam int K_RDY  = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset, we0, we1, alloc_en;
    logic [AW-1:0]       ain0, ain1, alloc_addr;
    logic [XLEN-1:0]     din0, din1;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_val_b, rs_val_n;
    logic [NRD-1:0]      rs_busy_b, rs_busy_n;
    logic                ready_b, ready_n;

    register_bank_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
        .clock(clock), .reset(reset),
        .we0(we0), .ain0(ain0), .din0(din0),
        .we1(we1), .ain1(ain1), .din1(din1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .rs_addr(rs_addr), .rs_val(rs_val_b), .rs_busy(rs_busy_b), .ready(ready_b)
    );

    register_bank_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset),
        .we0(we0), .ain0(ain0), .din0(din0),
        .we1(we1), .ain1(ain1), .din1(din1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .rs_addr(rs_addr), .rs_val(rs_val_n), .rs_busy(rs_busy_n), .ready(ready_n)
    );

    typedef struct {
        string       tag;
        int          dut;   // 0 = bypass build, 1 = no-bypass build
        int          port;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        q[$];
    exp_t        e_cur;
    logic [31:0] a_cur;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [XLEN-1:0] mdl_mem [NREGS];
    logic            mdl_pend [NREGS];

    function automatic logic [31:0] actual(input exp_t e);
        case (e.kind)
            K_VAL:   return (e.dut != 0) ? rs_val_n[e.port*XLEN +: XLEN] : rs_val_b[e.port*XLEN +: XLEN];
            K_BUSY:  return {31'b0, (e.dut != 0) ? rs_busy_n[e.port] : rs_busy_b[e.port]};
            default: return {31'b0, (e.dut != 0) ? ready_n : ready_b};
        endcase
    endfunction

    function automatic void push(input string tag, input int d, input int p, input int k, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.dut = d; e.port = p; e.kind = k; e.exp = v;
        q.push_back(e);
    endfunction

    task automatic idle();
        we0 = 1'b0; ain0 = '0; din0 = '0;
        we1 = 1'b0; ain1 = '0; din1 = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    task automatic set_rd(input int p, input int a);
        rs_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic test_reset();
        int cnt;
        idle();
        set_rd(0, 5); set_rd(1, 31);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            push("rst_ready", d, 0, K_RDY, 0);
            for (int p = 0; p < NRD; p++) begin
                push("clear_val", d, p, K_VAL, 0);
                push("clear_busy", d, p, K_BUSY, 0);
            end
        end
        while (q.size() > 0) begin
            e_cur = q.pop_front(); a_cur = actual(e_cur); n_checks++;
            if (a_cur !== e_cur.exp) begin
                n_errors++;
                $display("FAIL %s dut%0d port%0d: got 0x%0h, want 0x%0h", e_cur.tag, e_cur.dut, e_cur.port, a_cur, e_cur.exp);
            end
        end
        cnt = 0;
        while (ready_b !== 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clock); #1;
        end
        n_checks++;
        if (cnt !== NREGS - 1) begin
            n_errors++;
            $display("FAIL clear_len: ready low for %0d cycles, want %0d", cnt, NREGS - 1);
        end
        push("nb_ready", 1, 0, K_RDY, 1);
        for (int a = 0; a < NREGS; a++) begin
            @(negedge clock);
            set_rd(0, a); set_rd(1, NREGS - 1 - a);
            #1;
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < NRD; p++) begin
                    push("zero_after_clear", d, p, K_VAL, 0);
                    push("idle_after_clear", d, p, K_BUSY, 0);
                end
            while (q.size() > 0) begin
                e_cur = q.pop_front(); a_cur = actual(e_cur); n_checks++;
                if (a_cur !== e_cur.exp) begin
                    n_errors++;
                    $display("FAIL %s dut%0d port%0d: got 0x%0h, want 0x%0h", e_cur.tag, e_cur.dut, e_cur.port, a_cur, e_cur.exp);
                end
            end
        end
    endtask

    task automatic test_collision();
        @(negedge clock);
        we0 = 1'b1; ain0 = 5; din0 = 32'hAAAA_0000;
        we1 = 1'b1; ain1 = 5; din1 = 32'h0000_1234;
        set_rd(0, 5); set_rd(1, 5);
        #1;
        push("coll_bypass", 0, 0, K_VAL, 32'hAAAA_0000);
        push("coll_bypass", 0, 1, K_VAL, 32'hAAAA_0000);
        push("coll_nobypass_old", 1, 0, K_VAL, 0);
        for (int i = 0; i < 2; i++) begin
            while (q.size() > 0) begin
                e_cur = q.pop_front(); a_cur = actual(e_cur); n_checks++;
                if (a_cur !== e_cur.exp) begin
                    n_errors++;
                    $display("FAIL %s dut%0d port%0d: got 0x%0h, want 0x%0h", e_cur.tag, e_cur.dut, e_cur.port, a_cur, e_cur.exp);
                end
            end
            @(negedge clock); idle(); #1;
            for (int d = 0; d < 2; d++) push("coll_stored", d, 1, K_VAL, 32'hAAAA_0000);
        end
        q.delete();
    endtask

    task automatic test_zero_write();
        @(negedge clock);
        we0 = 1'b1; ain0 = 0; din0 = 32'hFFFF_FFFF;
        we1 = 1'b1; ain1 = 0; din1 = 32'hFFFF_FFFF;
        alloc_en = 1'b1; alloc_addr = 0;
        set_rd(0, 0); set_rd(1, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < NRD; p++) begin
                    push("r0_val", d, p, K_VAL, 0);
                    push("r0_busy", d, p, K_BUSY, 0);
                end
            while (q.size() > 0) begin
                e_cur = q.pop_front(); a_cur = actual(e_cur); n_checks++;
                if (a_cur !== e_cur.exp) begin
                    n_errors++;
                    $display("FAIL %s dut%0d port%0d: got 0x%0h, want 0x%0h", e_cur.tag, e_cur.dut, e_cur.port, a_cur, e_cur.exp);
                end
            end
            @(negedge clock); idle();
        end
    endtask

    task automatic test_alloc();
        // step: 0 alloc, 1 observe, 2 write+alloc, 3 observe, 4 plain write, 5 observe
        for (int s = 0; s < 6; s++) begin
            if (s != 0) @(negedge clock);
            idle();
            set_rd(0, 7); set_rd(1, 0);
            case (s)
                0: begin alloc_en = 1'b1; alloc_addr = 7; end
                2: begin alloc_en = 1'b1; alloc_addr = 7; we1 = 1'b1; ain1 = 7; din1 = 32'h0000_BEEF; end
                4: begin we0 = 1'b1; ain0 = 7; din0 = 32'h0000_0077; end
                default: ;
            endcase
            #1;
            case (s)
                0: push("busy_not_yet", 0, 0, K_BUSY, 0);
                1: begin push("busy_set", 0, 0, K_BUSY, 1); push("busy_set", 1, 0, K_BUSY, 1); push("busy_r0", 0, 1, K_BUSY, 0); end
                2: begin push("alloc_wr_bypass", 0, 0, K_VAL, 32'h0000_BEEF); push("alloc_wr_old", 1, 0, K_VAL, 0); push("busy_unbypassed", 0, 0, K_BUSY, 1); end
                3: for (int d = 0; d < 2; d++) begin push("alloc_wins", d, 0, K_BUSY, 1); push("alloc_wr_data", d, 0, K_VAL, 32'h0000_BEEF); end
                4: push("busy_before_clr", 0, 0, K_BUSY, 1);
                default: for (int d = 0; d < 2; d++) begin push("write_clears", d, 0, K_BUSY, 0); push("write_data", d, 0, K_VAL, 32'h77); end
            endcase
            while (q.size() > 0) begin
                e_cur = q.pop_front(); a_cur = actual(e_cur); n_checks++;
                if (a_cur !== e_cur.exp) begin
                    n_errors++;
                    $display("FAIL %s dut%0d port%0d: got 0x%0h, want 0x%0h", e_cur.tag, e_cur.dut, e_cur.port, a_cur, e_cur.exp);
                end
            end
        end
    endtask

    task automatic test_bypass();
        for (int s = 0; s < 4; s++) begin
            @(negedge clock);
            idle();
            set_rd(0, 3); set_rd(1, (s < 2) ? 3 : 4);
            if (s == 0) begin we1 = 1'b1; ain1 = 3; din1 = 32'h55; end
            if (s == 2) begin we0 = 1'b1; ain0 = 3; din0 = 32'h99; we1 = 1'b1; ain1 = 4; din1 = 32'h44; end
            #1;
            case (s)
                0: begin push("byp_new", 0, 0, K_VAL, 32'h55); push("nobyp_old", 1, 0, K_VAL, 0); push("nobyp_old", 1, 1, K_VAL, 0); end
                1: begin push("byp_next", 0, 0, K_VAL, 32'h55); push("nobyp_next", 1, 0, K_VAL, 32'h55); end
                2: begin push("byp_p0", 0, 0, K_VAL, 32'h99); push("byp_p1", 0, 1, K_VAL, 32'h44);
                         push("nobyp_p0_old", 1, 0, K_VAL, 32'h55); push("nobyp_p1_old", 1, 1, K_VAL, 0); end
                default: begin push("nobyp_p0_new", 1, 0, K_VAL, 32'h99); push("nobyp_p1_new", 1, 1, K_VAL, 32'h44); end
            endcase
            while (q.size() > 0) begin
                e_cur = q.pop_front(); a_cur = actual(e_cur); n_checks++;
                if (a_cur !== e_cur.exp) begin
                    n_errors++;
                    $display("FAIL %s dut%0d port%0d: got 0x%0h, want 0x%0h", e_cur.tag, e_cur.dut, e_cur.port, a_cur, e_cur.exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        @(negedge clock); idle(); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        repeat (9) @(negedge clock);      // clear index is now 10
        reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        set_rd(0, 9); set_rd(1, 12);
        #1;
        cnt = 0;
        while (ready_b !== 1'b1 && cnt < 100) begin
            cnt++;
            // Writes and allocs during CLEAR must be ignored.
            we0 = 1'b1; ain0 = 9; din0 = 32'hDEAD;
            alloc_en = 1'b1; alloc_addr = 12;
            @(negedge clock); #1;
        end
        idle();
        n_checks++;
        if (cnt !== NREGS - 1) begin
            n_errors++;
            $display("FAIL restart_len: ready low for %0d cycles, want %0d", cnt, NREGS - 1);
        end
        for (int a = 3; a <= 12; a++) begin
            @(negedge clock);
            set_rd(0, a); set_rd(1, a);
            #1;
            for (int d = 0; d < 2; d++) begin
                push("restart_val", d, 0, K_VAL, 0);
                push("restart_busy", d, 1, K_BUSY, 0);
            end
            while (q.size() > 0) begin
                e_cur = q.pop_front(); a_cur = actual(e_cur); n_checks++;
                if (a_cur !== e_cur.exp) begin
                    n_errors++;
                    $display("FAIL %s dut%0d port%0d: got 0x%0h, want 0x%0h", e_cur.tag, e_cur.dut, e_cur.port, a_cur, e_cur.exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit            w0, w1;
        int            a;
        logic [31:0]   vb;
        for (int i = 0; i < NREGS; i++) begin mdl_mem[i] = '0; mdl_pend[i] = 1'b0; end
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            we0 = 1'($urandom); ain0 = AW'($urandom_range(0, 7)); din0 = $urandom;
            we1 = 1'($urandom); ain1 = AW'($urandom_range(0, 7)); din1 = $urandom;
            alloc_en = 1'($urandom_range(0, 3) == 0); alloc_addr = AW'($urandom_range(0, 7));
            set_rd(0, $urandom_range(0, 7)); set_rd(1, $urandom_range(0, 7));
            #1;
            w0 = we0 && (ain0 != 0);
            w1 = we1 && (ain1 != 0) && !(w0 && ain0 == ain1);
            for (int p = 0; p < NRD; p++) begin
                a  = int'(rs_addr[p*AW +: AW]);
                vb = (a == 0) ? 32'h0 : (w0 && int'(ain0) == a) ? din0 : (w1 && int'(ain1) == a) ? din1 : mdl_mem[a];
                push("b2b_val_byp", 0, p, K_VAL, vb);
                push("b2b_val_nobyp", 1, p, K_VAL, (a == 0) ? 32'h0 : mdl_mem[a]);
                push("b2b_busy", 0, p, K_BUSY, {31'b0, (a != 0) && mdl_pend[a]});
            end
            while (q.size() > 0) begin
                e_cur = q.pop_front(); a_cur = actual(e_cur); n_checks++;
                if (a_cur !== e_cur.exp) begin
                    n_errors++;
                    $display("FAIL %s dut%0d port%0d: got 0x%0h, want 0x%0h", e_cur.tag, e_cur.dut, e_cur.port, a_cur, e_cur.exp);
                end
            end
            if (w1) begin mdl_mem[ain1] = din1; mdl_pend[ain1] = 1'b0; end
            if (w0) begin mdl_mem[ain0] = din0; mdl_pend[ain0] = 1'b0; end
            if (alloc_en && alloc_addr != 0) mdl_pend[alloc_addr] = 1'b1;
        end
        @(negedge clock); idle();
    endtask

    initial begin
        reset = 1'b1;
        rs_addr = '0;
        idle();
        test_reset();
        test_collision();
        test_zero_write();
        test_alloc();
        test_bypass();
        test_reset_mid_clear();
        test_back_to_back();
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
